// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the five-stage pipeline sequencing controller.
// Holds the FSM state encoding, drain length and the bundled stage controls.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } ctrl_state_e;

    localparam int unsigned DRAIN_CYCLES = 2;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
    } pipe_ctrl_s;

    function automatic pipe_ctrl_s ctrl_default();
        pipe_ctrl_s c;
        c = '0;
        c.pc_en     = 1'b1;
        c.if_id_en  = 1'b1;
        c.id_ex_en  = 1'b1;
        c.ex_mem_en = 1'b1;
        c.mem_wb_en = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipe_ctrl_load_use.sv
// Load-use hazard detection: a load in EX whose destination feeds the
// instruction currently in IF/ID.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs2,
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    output logic       hazard
);

    always_comb begin
        hazard = ex_memread && (ex_rd != 5'd0) &&
                 ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: load-use stalls, redirect squashes,
// data-memory wait states, halt drain and a saturating stall counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             ex_halt,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             halted,
    output logic             mem_err,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    ctrl_state_e        state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               ret_drain_q, ret_drain_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   stall_q;
    logic               load_use;
    logic               eval_en, eval_drain;
    pipe_ctrl_s         ctrl;

    load_use_detect u_load_use (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs2 (id_uses_rs2),
        .ex_memread  (ex_memread),
        .ex_rd       (ex_rd),
        .hazard      (load_use)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            wait_q      <= '0;
            drain_q     <= '0;
            ret_drain_q <= 1'b0;
            err_q       <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            drain_q     <= drain_d;
            ret_drain_q <= ret_drain_d;
            err_q       <= err_d;
            if (state_q != HALTED && !ctrl.pc_en && stall_q != '1)
                stall_q <= stall_q + 1'b1;
        end
    end

    // The MEM_WAIT release cycle is handled as an ordinary cycle of the
    // saved return state, so the RUN/DRAIN priority chain is shared.
    always_comb begin
        ctrl        = ctrl_default();
        state_d     = state_q;
        wait_d      = wait_q;
        drain_d     = drain_q;
        ret_drain_d = ret_drain_q;
        err_d       = err_q;
        eval_en     = 1'b0;
        eval_drain  = 1'b0;

        case (state_q)
            RUN: eval_en = 1'b1;
            DRAIN: begin
                eval_en    = 1'b1;
                eval_drain = 1'b1;
            end
            MEM_WAIT: begin
                if (!dmem_ready) begin
                    ctrl              = '0;
                    ctrl.mem_wb_en    = 1'b1;
                    ctrl.mem_wb_flush = 1'b1;
                    if (wait_q >= WAIT_W'(MAX_WAIT - 1)) begin
                        err_d   = 1'b1;
                        state_d = HALTED;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end else begin
                    eval_en    = 1'b1;
                    eval_drain = ret_drain_q;
                    state_d    = ret_drain_q ? DRAIN : RUN;
                end
            end
            default: ctrl = '0;
        endcase

        if (eval_en) begin
            if (mem_access && !dmem_ready) begin
                ctrl              = '0;
                ctrl.mem_wb_en    = 1'b1;
                ctrl.mem_wb_flush = 1'b1;
                state_d           = MEM_WAIT;
                wait_d            = WAIT_W'(1);
                ret_drain_d       = eval_drain;
            end else if (eval_drain) begin
                ctrl.pc_en       = 1'b0;
                ctrl.if_id_en    = 1'b0;
                ctrl.id_ex_flush = 1'b1;
                if (drain_q <= DRAIN_W'(1)) begin
                    drain_d = '0;
                    state_d = HALTED;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end else if (ex_halt) begin
                ctrl.pc_en       = 1'b0;
                ctrl.if_id_flush = 1'b1;
                ctrl.id_ex_flush = 1'b1;
                state_d          = DRAIN;
                drain_d          = DRAIN_W'(DRAIN_CYCLES);
            end else if (ex_redirect) begin
                ctrl.if_id_flush = 1'b1;
                ctrl.id_ex_flush = 1'b1;
            end else if (load_use) begin
                ctrl.pc_en       = 1'b0;
                ctrl.if_id_en    = 1'b0;
                ctrl.id_ex_flush = 1'b1;
            end
        end

        if (!reset)
            ctrl = '0;
    end

    assign pc_en        = ctrl.pc_en;
    assign if_id_en     = ctrl.if_id_en;
    assign id_ex_en     = ctrl.id_ex_en;
    assign ex_mem_en    = ctrl.ex_mem_en;
    assign mem_wb_en    = ctrl.mem_wb_en;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign mem_wb_flush = ctrl.mem_wb_flush;
    assign halted       = (state_q == HALTED);
    assign mem_err      = err_q;
    assign state        = state_q;
    assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
// Control vector order: pc,if_id,id_ex,ex_mem,mem_wb enables; if_id,id_ex,mem_wb flushes.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs2, ex_memread, ex_redirect, ex_halt, mem_access, dmem_ready;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, mem_wb_flush;
    logic        halted, mem_err;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic [7:0]  ctl;
    int          checks = 0;
    int          failures = 0;
    int          edges;

    pipe_ctrl #(.MAX_WAIT(15), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .ex_halt(ex_halt), .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
        .halted(halted), .mem_err(mem_err), .state(state), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                  if_id_flush, id_ex_flush, mem_wb_flush};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0; id_uses_rs2 = 1'b0;
        ex_memread = 1'b0; ex_redirect = 1'b0; ex_halt = 1'b0;
        mem_access = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        idle();
        #2;
        chk("reset_ctl",   32'(ctl), 32'h00);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_cnt",   32'(stall_cnt), 32'd0);
        chk("reset_flags", 32'({halted, mem_err}), 32'd0);
        reset = 1'b1;
        tick();
        #1 chk("run_idle", 32'(ctl), 32'hF8);

        // load-use via rs1
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
        #1 chk("lu_rs1_ctl", 32'(ctl), 32'h3A);
        tick();
        idle();
        #1 chk("lu_after_ctl", 32'(ctl), 32'hF8);
        chk("lu_cnt", 32'(stall_cnt), 32'd1);

        // load-use via rs2, gated by id_uses_rs2
        ex_memread = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b0;
        #1 chk("lu_rs2_unused", 32'(ctl), 32'hF8);
        id_uses_rs2 = 1'b1;
        #1 chk("lu_rs2_ctl", 32'(ctl), 32'h3A);
        tick();
        idle();

        // zero destination never stalls
        ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
        #1 chk("lu_x0_ctl", 32'(ctl), 32'hF8);
        tick();
        chk("lu_x0_cnt", 32'(stall_cnt), 32'd2);

        // redirect beats load-use
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; ex_redirect = 1'b1;
        #1 chk("redir_ctl", 32'(ctl), 32'hFE);
        tick();
        idle();
        #1 chk("redir_cnt", 32'(stall_cnt), 32'd2);

        // 3 wait cycles, release on the 4th
        mem_access = 1'b1; dmem_ready = 1'b0;
        #1 chk("mw1_ctl", 32'(ctl), 32'h09);
        chk("mw1_state", 32'(state), 32'd0);
        tick();
        #1 chk("mw2_ctl", 32'(ctl), 32'h09);
        chk("mw2_state", 32'(state), 32'd1);
        tick();
        #1 chk("mw3_ctl", 32'(ctl), 32'h09);
        chk("mw3_state", 32'(state), 32'd1);
        tick();
        dmem_ready = 1'b1;
        #1 chk("mw_rel_ctl", 32'(ctl), 32'hF8);
        chk("mw_rel_state", 32'(state), 32'd1);
        tick();
        idle();
        #1 chk("mw_done_state", 32'(state), 32'd0);
        chk("mw_cnt", 32'(stall_cnt), 32'd5);

        // halt drain: 3 edges
        ex_halt = 1'b1;
        #1 chk("halt_ctl", 32'(ctl), 32'h7E);
        tick();
        idle();
        #1 chk("drain1_ctl", 32'(ctl), 32'h3A);
        chk("drain1_state", 32'(state), 32'd2);
        tick();
        #1 chk("drain2_halted", 32'(halted), 32'd0);
        tick();
        #1 chk("halted_e3", 32'(halted), 32'd1);
        chk("halted_ctl", 32'(ctl), 32'h00);
        tick(); tick();
        #1 chk("halted_stays", 32'({halted, state}), 32'h7);
        chk("halted_cnt", 32'(stall_cnt), 32'd8);

        do_reset();
        #1 chk("rst_from_halt", 32'({halted, state, stall_cnt}), 32'd0);

        // halt with a 2-cycle wait inside DRAIN: 5 edges
        ex_halt = 1'b1;
        #1 tick();
        idle();
        mem_access = 1'b1; dmem_ready = 1'b0;
        #1 chk("dmw_ctl", 32'(ctl), 32'h09);
        tick();
        #1 chk("dmw_state", 32'(state), 32'd1);
        tick();
        dmem_ready = 1'b1;
        #1 chk("dmw_rel_ctl", 32'(ctl), 32'h3A);
        tick();
        idle();
        #1 chk("dmw_e4", 32'({halted, state}), 32'd2);
        tick();
        #1 chk("dmw_e5_halted", 32'(halted), 32'd1);
        chk("dmw_cnt", 32'(stall_cnt), 32'd5);

        do_reset();

        // timeout after 15 wait cycles
        mem_access = 1'b1; dmem_ready = 1'b0;
        edges = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            edges = i;
            if (state == 2'd3) break;
        end
        chk("to_edges", 32'(edges), 32'd15);
        chk("to_err", 32'({mem_err, halted}), 32'h3);
        chk("to_cnt", 32'(stall_cnt), 32'd15);

        do_reset();
        idle();

        // reset mid-wait
        mem_access = 1'b1; dmem_ready = 1'b0;
        tick(); tick(); tick();
        chk("pre_rst_state", 32'(state), 32'd1);
        reset = 1'b0;
        #1 chk("midrst_ctl", 32'(ctl), 32'h00);
        chk("midrst_all", 32'({halted, mem_err, state, stall_cnt}), 32'd0);
        idle();
        #1 reset = 1'b1;
        #1 chk("post_rst_run", 32'(ctl), 32'hF8);
        tick();
        chk("post_rst_state", 32'(state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Sequencing controller for the five-stage RISC-V pipeline: it drives load-enable and bubble-insert (flush) controls for the PC and the four pipeline buffer registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It resolves load-use stalls, taken-branch/JAL squashes, and data-memory wait states. It also sequences the halt drain and counts stall cycles. It sits beside the datapath in the top level and contains no datapath storage of its own.

## Interface
Parameters:
- `MAX_WAIT`, 15: data-memory wait cycles tolerated before a timeout error.
- `CNT_W`, 16: width of the stall counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `id_rs1`, `id_rs2` in 5 each: source registers of the instruction in IF/ID.
- `id_uses_rs2` in 1: the IF/ID instruction reads rs2.
- `ex_memread` in 1: the ID/EX instruction is a load.
- `ex_rd` in 5: destination register of the ID/EX instruction.
- `ex_redirect` in 1: taken branch or Jal resolved in EX.
- `ex_halt` in 1: Halt is in EX.
- `mem_access` in 1: EX/MEM holds a MemRead or MemWrite.
- `dmem_ready` in 1: data memory completes the access this cycle.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en` out 1 each: register load enables.
- `if_id_flush`, `id_ex_flush`, `mem_wb_flush` out 1 each: load an all-zero bubble at the next edge. Flush overrides en.
- `halted` out 1: the pipeline is stopped after a Halt.
- `mem_err` out 1: sticky data-memory timeout.
- `state` out 2: current FSM state.
- `stall_cnt` out `CNT_W`: saturating count of cycles with `pc_en`=0.

## Operation
FSM states: RUN, MEM_WAIT, DRAIN, HALTED. Outputs are Mealy, a function of state and inputs. Defaults: every enable is 1 and every flush is 0.

Priority within RUN and DRAIN, highest first:
1. **Memory stall**, when `mem_access` && !`dmem_ready`:
   - All enables are 0 except `mem_wb_en`; `mem_wb_flush`=1.
   - Next state is MEM_WAIT; the wait counter loads 1.
   - `ex_redirect` and `ex_halt` are ignored, because EX is frozen and re-presents them.
2. **Halt**, when `ex_halt` in RUN:
   - `pc_en`=0, `if_id_flush`=1, `id_ex_flush`=1.
   - Next state is DRAIN; the drain counter loads 2.
3. **Redirect**, when `ex_redirect`:
   - `if_id_flush`=1, `id_ex_flush`=1.
   - `pc_en`=1 (the PC loads the target; target select is external).
4. **Load-use**, when `ex_memread` && `ex_rd`≠0 && (`ex_rd`==`id_rs1` || (`id_uses_rs2` && `ex_rd`==`id_rs2`)):
   - `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1.

MEM_WAIT:
- While !`dmem_ready`, outputs match the memory-stall case and the wait counter increments.
- When the counter reaches `MAX_WAIT`, set `mem_err` and go to HALTED.
- When `dmem_ready`=1, all enables are 1 that cycle; return to the saved return state (RUN or DRAIN, held in one flag).
- Lower-priority conditions are evaluated normally in the release cycle.

DRAIN:
- `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1.
- EX/MEM and MEM/WB advance.
- The drain counter decrements on each non-stalled cycle. When it reaches 0, go to HALTED.

HALTED:
- All enables are 0 and all flushes are 0.
- `halted`=1; it is left only by reset.

`stall_cnt` increments on every cycle with `pc_en`=0 while not in HALTED. It saturates at all-ones.

## Timing
- While `reset`=0: state=RUN, all counters 0, `mem_err`=0, `halted`=0, all enables 0, all flushes 0. Assertion of `reset` mid-stall or mid-drain aborts the operation immediately.
- After `reset` deasserts, the first edge behaves as RUN.
- Stall and flush controls respond in the same cycle as their cause, with zero-cycle latency. They take effect at the next edge.
- Load-use costs exactly 1 bubble. A redirect costs 2 squashed instructions.
- Halt → `halted`=1 takes 3 edges with no memory stalls, plus 1 per wait cycle.
- A load-use and a redirect in the same cycle: the redirect wins and no stall occurs.

## Structure
- `pipe_ctrl_pkg` holds:
  - the `ctrl_state_e` enum (RUN=0, MEM_WAIT=1, DRAIN=2, HALTED=3);
  - the `DRAIN_CYCLES`=2 constant;
  - a packed `pipe_ctrl_s` struct bundling the enables and flushes for connection to the buffer registers.
- One combinational sub-module, `load_use_detect`, implements the register comparison (term 4 of the priority list).

## Test plan
- **Load-use:** `ex_memread`=1, `ex_rd`=5, `id_rs1`=5 → exactly one cycle with `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1; `stall_cnt`=1.
- **Zero destination:** same as load-use with `ex_rd`=0 → no stall.
- **Redirect beats load-use:** `ex_redirect`=1 together with the load-use condition → `if_id_flush`=`id_ex_flush`=1, `pc_en`=1.
- **Memory wait:** `mem_access`=1, `dmem_ready` low for 3 cycles → 3 frozen cycles with `mem_wb_flush`=1 and `state`=1; release on the 4th cycle; `stall_cnt`=3.
- **Halt drain:**
  - `ex_halt` pulse → `halted`=1 after 3 edges and stays there.
  - With a 2-cycle memory wait during DRAIN → `halted`=1 after 5 edges.
- **Timeout and reset:**
  - `dmem_ready` held 0 → `mem_err`=1 and HALTED after 15 wait cycles.
  - `reset` pulsed low mid-wait → all outputs cleared and `state`=0.
